// File: rtl/regfile_sb.sv
// Purpose: 32 x 64-bit integer register file with a busy-bit scoreboard for decode RAW stalls.
// Latency: reads and busy lookups are combinational with write-through bypass; writes and scoreboard updates land on the next edge.
// Backpressure: none; decode consumes the busy outputs and stalls on its own.
module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   reg_waddr_i,
    input  logic [XLEN-1:0] reg_wdata_i,
    input  logic            reg_wen_i,
    input  logic [AW-1:0]   reg1_raddr_i,
    input  logic [AW-1:0]   reg2_raddr_i,
    output logic [XLEN-1:0] reg1_rdata_o,
    output logic [XLEN-1:0] reg2_rdata_o,
    input  logic            sb_set_i,
    input  logic [AW-1:0]   sb_set_addr_i,
    input  logic            flush_i,
    output logic            reg1_busy_o,
    output logic            reg2_busy_o,
    output logic [AW:0]     sb_cnt_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     sb_cnt_q;
    logic [AW:0]     sb_cnt_d;

    // A writeback that targets x0 is architecturally a no-op.
    logic wr_hit_any;
    assign wr_hit_any = reg_wen_i && (reg_waddr_i != '0);

    // Register array: synchronous clear, single write port, x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit_any) begin
            regs_q[reg_waddr_i] <= reg_wdata_i;
        end
    end

    // Scoreboard next state: flush beats issue, issue beats retire, x0 stays clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (sb_set_i && (sb_set_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (reg_wen_i && (reg_waddr_i == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Popcount of the next busy vector so the count tracks busy on the same edge.
    always_comb begin
        sb_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            sb_cnt_d = sb_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Scoreboard state and its population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            sb_cnt_q <= '0;
        end else begin
            busy_q   <= busy_d;
            sb_cnt_q <= sb_cnt_d;
        end
    end

    // Read ports: x0 is hardwired zero, a same-cycle writeback is forwarded.
    always_comb begin
        reg1_rdata_o = regs_q[reg1_raddr_i];
        if (reg1_raddr_i == '0) begin
            reg1_rdata_o = '0;
        end else if (reg_wen_i && (reg_waddr_i == reg1_raddr_i)) begin
            reg1_rdata_o = reg_wdata_i;
        end
        reg2_rdata_o = regs_q[reg2_raddr_i];
        if (reg2_raddr_i == '0) begin
            reg2_rdata_o = '0;
        end else if (reg_wen_i && (reg_waddr_i == reg2_raddr_i)) begin
            reg2_rdata_o = reg_wdata_i;
        end
    end

    // Busy lookups: a retiring producer is already being bypassed, so it does not stall.
    always_comb begin
        reg1_busy_o = busy_q[reg1_raddr_i]
                      && !(reg_wen_i && (reg_waddr_i == reg1_raddr_i))
                      && (reg1_raddr_i != '0);
        reg2_busy_o = busy_q[reg2_raddr_i]
                      && !(reg_wen_i && (reg_waddr_i == reg2_raddr_i))
                      && (reg2_raddr_i != '0);
    end

    assign sb_cnt_o = sb_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_waddr_i;
    logic [63:0] reg_wdata_i;
    logic        reg_wen_i;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic [63:0] reg1_rdata_o;
    logic [63:0] reg2_rdata_o;
    logic        sb_set_i;
    logic [4:0]  sb_set_addr_i;
    logic        flush_i;
    logic        reg1_busy_o;
    logic        reg2_busy_o;
    logic [5:0]  sb_cnt_o;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.XLEN(64), .NREG(32), .AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_waddr_i   (reg_waddr_i),
        .reg_wdata_i   (reg_wdata_i),
        .reg_wen_i     (reg_wen_i),
        .reg1_raddr_i  (reg1_raddr_i),
        .reg2_raddr_i  (reg2_raddr_i),
        .reg1_rdata_o  (reg1_rdata_o),
        .reg2_rdata_o  (reg2_rdata_o),
        .sb_set_i      (sb_set_i),
        .sb_set_addr_i (sb_set_addr_i),
        .flush_i       (flush_i),
        .reg1_busy_o   (reg1_busy_o),
        .reg2_busy_o   (reg2_busy_o),
        .sb_cnt_o      (sb_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_wen_i     = 1'b0;
        reg_waddr_i   = '0;
        reg_wdata_i   = '0;
        sb_set_i      = 1'b0;
        sb_set_addr_i = '0;
        flush_i       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            reg1_raddr_i = 5'(a);
            reg2_raddr_i = 5'(31 - a);
            #1;
            chk({tag, "_rd1"}, reg1_rdata_o, 64'h0);
            chk({tag, "_rd2"}, reg2_rdata_o, 64'h0);
            chk({tag, "_bsy1"}, 64'(reg1_busy_o), 64'h0);
            chk({tag, "_bsy2"}, 64'(reg2_busy_o), 64'h0);
        end
        chk({tag, "_cnt"}, 64'(sb_cnt_o), 64'h0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        reg1_raddr_i = '0;
        reg2_raddr_i = '0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Write x5 with same-cycle bypass, then read the stored copy.
        reg_wen_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 64'hDEADBEEF_CAFEF00D;
        reg1_raddr_i = 5'd5; reg2_raddr_i = 5'd6;
        #1;
        chk("x5_bypass", reg1_rdata_o, 64'hDEADBEEF_CAFEF00D);
        chk("x6_untouched", reg2_rdata_o, 64'h0);
        step();
        idle();
        reg2_raddr_i = 5'd5;
        #1;
        chk("x5_stored_p1", reg1_rdata_o, 64'hDEADBEEF_CAFEF00D);
        chk("x5_stored_p2", reg2_rdata_o, 64'hDEADBEEF_CAFEF00D);

        // x0 write and scoreboard set are both discarded.
        reg_wen_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 64'h1234;
        sb_set_i = 1'b1; sb_set_addr_i = 5'd0;
        reg1_raddr_i = 5'd0; reg2_raddr_i = 5'd0;
        #1;
        chk("x0_nobypass_p1", reg1_rdata_o, 64'h0);
        chk("x0_nobypass_p2", reg2_rdata_o, 64'h0);
        step();
        idle();
        #1;
        chk("x0_rd1", reg1_rdata_o, 64'h0);
        chk("x0_rd2", reg2_rdata_o, 64'h0);
        chk("x0_busy", 64'(reg1_busy_o), 64'h0);
        chk("x0_cnt", 64'(sb_cnt_o), 64'h0);

        // Issue to x7, then retire it.
        sb_set_i = 1'b1; sb_set_addr_i = 5'd7;
        step();
        idle();
        reg1_raddr_i = 5'd7;
        #1;
        chk("x7_busy", 64'(reg1_busy_o), 64'h1);
        chk("x7_cnt1", 64'(sb_cnt_o), 64'h1);
        reg_wen_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 64'h42;
        #1;
        chk("x7_retire_busy", 64'(reg1_busy_o), 64'h0);
        chk("x7_retire_data", reg1_rdata_o, 64'h42);
        step();
        idle();
        #1;
        chk("x7_cnt0", 64'(sb_cnt_o), 64'h0);
        chk("x7_after_busy", 64'(reg1_busy_o), 64'h0);
        chk("x7_after_data", reg1_rdata_o, 64'h42);

        // x9: set and retire in the same cycle, set wins.
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        step();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 64'h1;
        reg1_raddr_i = 5'd9;
        #1;
        chk("x9_pre_cnt", 64'(sb_cnt_o), 64'h1);
        chk("x9_same_cycle_busy", 64'(reg1_busy_o), 64'h0);
        step();
        idle();
        #1;
        chk("x9_still_busy", 64'(reg1_busy_o), 64'h1);
        chk("x9_data", reg1_rdata_o, 64'h1);
        chk("x9_cnt", 64'(sb_cnt_o), 64'h1);
        // Second producer on an already-busy register keeps a single bit.
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        step();
        idle();
        #1;
        chk("x9_reset_busy", 64'(reg1_busy_o), 64'h1);
        chk("x9_reset_cnt", 64'(sb_cnt_o), 64'h1);
        reg_wen_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 64'h2;
        step();
        idle();
        #1;
        chk("x9_cleared_busy", 64'(reg1_busy_o), 64'h0);
        chk("x9_cleared_cnt", 64'(sb_cnt_o), 64'h0);
        chk("x9_data2", reg1_rdata_o, 64'h2);

        // Three producers, then a flush with a concurrent issue and writeback.
        sb_set_i = 1'b1; sb_set_addr_i = 5'd1;
        step();
        sb_set_addr_i = 5'd2;
        step();
        sb_set_addr_i = 5'd3;
        step();
        idle();
        reg1_raddr_i = 5'd2; reg2_raddr_i = 5'd3;
        #1;
        chk("three_cnt", 64'(sb_cnt_o), 64'h3);
        chk("x2_busy", 64'(reg1_busy_o), 64'h1);
        chk("x3_busy", 64'(reg2_busy_o), 64'h1);
        flush_i = 1'b1;
        sb_set_i = 1'b1; sb_set_addr_i = 5'd4;
        reg_wen_i = 1'b1; reg_waddr_i = 5'd1; reg_wdata_i = 64'h77;
        step();
        idle();
        reg1_raddr_i = 5'd4; reg2_raddr_i = 5'd1;
        #1;
        chk("flush_x4_busy", 64'(reg1_busy_o), 64'h0);
        chk("flush_x1_busy", 64'(reg2_busy_o), 64'h0);
        chk("flush_cnt", 64'(sb_cnt_o), 64'h0);
        chk("flush_x1_data", reg2_rdata_o, 64'h77);
        reg1_raddr_i = 5'd3;
        #1;
        chk("flush_x3_busy", 64'(reg1_busy_o), 64'h0);

        // Issue before reset so reset must clear live state, and reset must ignore inputs.
        sb_set_i = 1'b1; sb_set_addr_i = 5'd11;
        step();
        idle();
        #1;
        chk("pre_rst_cnt", 64'(sb_cnt_o), 64'h1);
        rst = 1'b1;
        reg_wen_i = 1'b1; reg_waddr_i = 5'd10; reg_wdata_i = 64'h5555;
        sb_set_i = 1'b1; sb_set_addr_i = 5'd12;
        step();
        rst = 1'b0;
        idle();
        check_all_zero("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- 32 x 64-bit integer register file with a busy-bit scoreboard.
- Receiving end of the writeback interface: consumes the reg_waddr/reg_wdata/reg_wen triple driven by wb.
- Serves the two decode-stage read ports.
- Tracks registers with an in-flight producer so that decode can stall on RAW hazards.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_waddr_i  input  AW  writeback destination register.
- reg_wdata_i  input  XLEN  writeback data.
- reg_wen_i  input  1  writeback write enable.
- reg1_raddr_i  input  AW  read port 1 address.
- reg2_raddr_i  input  AW  read port 2 address.
- reg1_rdata_o  output  XLEN  read port 1 data.
- reg2_rdata_o  output  XLEN  read port 2 data.
- sb_set_i  input  1  decode issued an instruction that writes sb_set_addr_i.
- sb_set_addr_i  input  AW  destination of the issued instruction.
- flush_i  input  1  pipeline flush; drops all pending producers.
- reg1_busy_o  output  1  read port 1 register has an unretired producer.
- reg2_busy_o  output  1  read port 2 register has an unretired producer.
- sb_cnt_o  output  AW+1  number of busy registers (0..NREG).

Behaviour:
- Reset:
  - When rst=1 at a rising edge, all registers clear to 0 and the busy vector clears to 0.
  - All other inputs are ignored that cycle.
  - Outputs after reset: rdata=0, busy=0, sb_cnt_o=0.
- x0 handling:
  - x0 reads 0 always.
  - A write to x0 is discarded.
  - sb_set with addr 0 is ignored; busy[0] is constantly 0.
- Write:
  - At a rising edge with reg_wen_i=1 and reg_waddr_i!=0, regs[reg_waddr_i] <= reg_wdata_i.
  - Write latency is 1 cycle.
- Read:
  - Combinational, 0-cycle latency.
  - Write-through bypass: if reg_wen_i=1, reg_waddr_i==raddr and raddr!=0, rdata = reg_wdata_i in the same cycle. Otherwise rdata = regs[raddr].
  - Each port bypasses independently; both ports may hit the same address.
- Scoreboard, per register i!=0, evaluated at the rising edge in priority order:
  1. flush_i=1: busy[i] <= 0. sb_set_i is ignored that cycle, but the register write still commits because writeback is older than the flush.
  2. sb_set_i=1 and sb_set_addr_i==i: busy[i] <= 1. Set wins over a same-cycle clear, because the new producer is younger than the retiring one.
  3. reg_wen_i=1 and reg_waddr_i==i: busy[i] <= 0.
  4. Otherwise busy[i] holds.
- Busy outputs:
  - regN_busy_o = busy[raddr] AND NOT (reg_wen_i AND reg_waddr_i==raddr).
  - The retiring value is bypassed, so decode does not stall on it.
  - Any access to x0 gives 0.
- Multiple producers:
  - A second sb_set to an already-busy register keeps it busy.
  - The first writeback to that register clears it; the scoreboard is a single bit, not a counter. Decode guarantees in-order writeback, so this is acceptable.
- sb_cnt_o:
  - Registered popcount of the busy vector, updated in the same edge as busy.
  - Always equals the number of set bits of the current busy vector.
  - Range 0..31; bit AW reaches 1 only when NREG-1 >= 2^AW, so it stays 0 for the default parameters.
- reg_wen_i=0 with any reg_waddr_i: no state change from the write path.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rdata=0, busy=0, sb_cnt_o=0.
- Write x5=0xDEADBEEF_CAFEF00D; during that cycle read x5 on port1 -> same-cycle bypass gives 0xDEADBEEF_CAFEF00D. Next cycle with wen=0 -> the stored value is returned.
- Write x0=0x1234 and sb_set addr 0; read x0 on both ports -> 0, reg1_busy_o=0, sb_cnt_o unchanged.
- sb_set x7; next cycle read x7 -> reg1_busy_o=1, sb_cnt_o=1. Writeback x7=0x42 -> that cycle busy=0 and rdata=0x42; after the edge sb_cnt_o=0.
- Same cycle: sb_set x9 and writeback x9=0x1 with x9 previously busy -> after the edge x9 stays busy, regs[9]=0x1, sb_cnt_o unchanged.
- Set x1,x2,x3 on consecutive cycles (sb_cnt_o=3), then flush_i together with sb_set x4 and writeback x1=0x77 -> all busy=0, sb_cnt_o=0, x4 not busy, regs[1]=0x77. Then assert rst mid-stream -> all registers read 0.
